// File: rtl/mem_pkg.sv
// Shared opcodes, FSM states and access-size decode for the memory stage.
// The optional misalignment trap is selected with MEM_MISALIGN_TRAP_EN.
package mem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;
    typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} size_t;

    // Unknown opcodes that still reach memory are treated as word accesses.
    function automatic size_t op_size(input logic [5:0] op);
        size_t sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = BYTE;
            OP_LH, OP_LHU, OP_SH: sz = HALF;
            default:              sz = WORD;
        endcase
        return sz;
    endfunction

    function automatic logic op_signed(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

    function automatic logic is_misaligned(input size_t sz, input logic [1:0] lo);
        logic r;
        case (sz)
            HALF:    r = lo[0];
            WORD:    r = |lo;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
// BIG_ENDIAN mirrors byte lanes (k -> 3-k) for both directions.
module mem_align import mem_pkg::*; #(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  size_t       size,
    input  logic        sign_ext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [1:0]  lane_s;
    logic        half_hi_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Mirroring the byte lanes also swaps which halfword slot is addressed.
    assign lane_s    = BIG_ENDIAN ? ~addr_lo : addr_lo;
    assign half_hi_s = BIG_ENDIAN ? ~addr_lo[1] : addr_lo[1];
    assign half_s    = half_hi_s ? load_word[31:16] : load_word[15:0];

    // Pick the addressed byte of the read word.
    always_comb begin
        case (lane_s)
            2'd0:    byte_s = load_word[7:0];
            2'd1:    byte_s = load_word[15:8];
            2'd2:    byte_s = load_word[23:16];
            2'd3:    byte_s = load_word[31:24];
            default: byte_s = 8'h00;
        endcase
    end

    // Size-dependent enables, replicated store data and extended load data.
    always_comb begin
        case (size)
            BYTE: begin
                be        = 4'b0001 << lane_s;
                wdata     = {4{store_data[7:0]}};
                load_data = sign_ext ? {{24{byte_s[7]}}, byte_s} : {24'h000000, byte_s};
            end
            HALF: begin
                be        = half_hi_s ? 4'b1100 : 4'b0011;
                wdata     = {2{store_data[15:0]}};
                load_data = sign_ext ? {{16{half_s[15]}}, half_s} : {16'h0000, half_s};
            end
            default: begin
                be        = 4'b1111;
                wdata     = store_data;
                load_data = load_word;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: req/ack data-memory FSM with upstream freeze, timeout and
// registered result/forwarding outputs. MEM_MISALIGN_TRAP_EN enables the misalignment trap.
module mem_stage import mem_pkg::*; #(
    parameter bit          BIG_ENDIAN     = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instr1_PR,
    input  logic [31:0] aluResult1_PR,
    input  logic [31:0] readDataB1_PR,
    input  logic [4:0]  writeRegister1_PR,
    input  logic        MemRead1_PR,
    input  logic        MemWrite1_PR,
    input  logic        MemtoReg1_PR,
    input  logic        do_writeback1_PR,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        FREEZE,
    output logic [31:0] Data1_MEM,
    output logic [4:0]  writeRegister1_MEM,
    output logic        do_writeback1_MEM,
    output logic        MemtoReg1_MEM,
    output logic        bus_error,
    output logic        misalign_trap
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  cnt_r;
    logic [31:0] hold_r;
    logic        berr_r;
    logic        trap_r;
    logic        mem_op_s;
    logic        misalign_s;
    logic        freeze_s;
    logic        ack_s;
    logic        timeout_s;
    logic        abort_s;
    size_t       size_s;
    logic        sign_s;
    logic [3:0]  align_be_s;
    logic [31:0] align_wdata_s;
    logic [31:0] load_data_s;
    logic        unused_instr_s;

    assign mem_op_s       = MemRead1_PR | MemWrite1_PR;
    assign size_s         = op_size(Instr1_PR[31:26]);
    assign sign_s         = op_signed(Instr1_PR[31:26]);
    assign unused_instr_s = ^Instr1_PR[25:0];

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_s = mem_op_s & is_misaligned(size_s, aluResult1_PR[1:0]);
`else
    assign misalign_s = 1'b0;
`endif

    // Request and stall are forced low while RESET is high, even mid-access.
    assign freeze_s  = mem_op_s & (state_r != DONE);
    assign FREEZE    = ~RESET & freeze_s;
    assign dmem_req  = ~RESET & (((state_r == IDLE) & mem_op_s & ~misalign_s) | (state_r == WAIT));
    assign ack_s     = dmem_req & dmem_ack;
    assign timeout_s = (state_r == WAIT) & ~ack_s & (cnt_r == CNT_LAST);
    assign abort_s   = berr_r | trap_r;

    // Upstream is frozen until DONE, so these fields stay constant until ack.
    assign dmem_we    = MemWrite1_PR;
    assign dmem_addr  = {aluResult1_PR[31:2], 2'b00};
    assign dmem_be    = MemWrite1_PR ? align_be_s : 4'b1111;
    assign dmem_wdata = align_wdata_s;

    mem_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
        .size       (size_s),
        .sign_ext   (sign_s),
        .addr_lo    (aluResult1_PR[1:0]),
        .store_data (readDataB1_PR),
        .load_word  (hold_r),
        .be         (align_be_s),
        .wdata      (align_wdata_s),
        .load_data  (load_data_s)
    );

    // Next-state logic for the access FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (mem_op_s) begin
                    if (misalign_s || ack_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (ack_s || timeout_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state, wait counter, read-data hold and per-access fault flags.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
            hold_r  <= 32'h0000_0000;
            berr_r  <= 1'b0;
            trap_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= ((state_r == WAIT) && (state_nxt_s == WAIT)) ? cnt_r + 8'd1 : 8'd0;
            if (ack_s) begin
                hold_r <= dmem_rdata;
            end
            berr_r  <= timeout_s;
            trap_r  <= (state_r == IDLE) & mem_op_s & misalign_s;
        end
    end

    // Result and forwarding registers advance whenever the stage is not stalled.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            Data1_MEM          <= 32'h0000_0000;
            writeRegister1_MEM <= 5'd0;
            do_writeback1_MEM  <= 1'b0;
            MemtoReg1_MEM      <= 1'b0;
        end else if (!freeze_s) begin
            Data1_MEM          <= abort_s ? 32'h0000_0000 :
                                  (MemRead1_PR ? load_data_s : aluResult1_PR);
            writeRegister1_MEM <= writeRegister1_PR;
            do_writeback1_MEM  <= do_writeback1_PR & ~MemWrite1_PR & ~abort_s;
            MemtoReg1_MEM      <= MemtoReg1_PR;
        end
    end

    assign bus_error     = berr_r;
    assign misalign_trap = trap_r;

endmodule
